pixel_frame_buffer: RTL and testbench
=====================================

# pixel_frame_buffer

Parametrised single-port frame store for camera/grayscale pixel streams. Holds one IMG_W×IMG_H frame of DW-bit pixels in a register array. Accepts whole-frame write, read and clear commands from the controller. Exchanges pixels with upstream (grayscale) and downstream modules over valid/ready handshakes with back-pressure on both sides, and supplies row/frame markers on the read side.

## Interface
- DW, 8: pixel data width in bits
- IMG_W, 2: frame width in pixels (≥1)
- IMG_H, 2: frame height in pixels (≥1)
- CLR_VAL, 0: DW-bit value written to every location by a clear
- Derived, not overridable: DEPTH = IMG_W*IMG_H; AW = max(1, $clog2(DEPTH))

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  command qualifier from controller; also the abort control while busy
- rw  in  1  0 = read frame, 1 = write frame; sampled only at command acceptance
- clear  in  1  request to clear the frame; sampled only at command acceptance
- wr_valid  in  1  upstream pixel present on wr_data
- wr_data  in  DW  upstream pixel
- wr_ready  out  1  buffer accepts a pixel this cycle
- rd_ready  in  1  downstream accepts rd_data this cycle
- rd_valid  out  1  rd_data holds a valid pixel
- rd_data  out  DW  pixel at the current address; 0 when rd_valid = 0
- rd_eol  out  1  the current read pixel is the last of its row
- rd_last  out  1  the current read pixel is the last of the frame
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when a command completes normally

## Operation
- States: IDLE, WRITE, READ, CLEAR. Address counter `addr` (AW bits) and column counter `col` track position; `col` wraps at IMG_W-1.
- IDLE: addr = 0, col = 0. When enable = 1, a command is accepted. Priority: clear → CLEAR, else rw = 1 → WRITE, else → READ. When enable = 0, stay in IDLE.
- WRITE:
  - wr_ready = 1.
  - On wr_valid & wr_ready: mem[addr] ← wr_data, then addr and col advance.
  - On the transfer at addr = DEPTH-1: go to IDLE and pulse done.
  - wr_valid low simply stalls; there is no separate wait state and addr is preserved.
- READ:
  - rd_valid = 1 and rd_data = mem[addr], combinational from the registered addr.
  - rd_eol = (col == IMG_W-1); rd_last = (addr == DEPTH-1).
  - On rd_valid & rd_ready: advance. While rd_ready = 0, rd_data, rd_eol and rd_last hold stable.
  - On the transfer with rd_last = 1: go to IDLE and pulse done.
- CLEAR: mem[addr] ← CLR_VAL once per cycle, unconditionally. After the write at addr = DEPTH-1: go to IDLE and pulse done. Exactly DEPTH locations are written; addr never exceeds DEPTH-1.
- Abort: enable = 0 in WRITE, READ or CLEAR → IDLE on the next edge, no done, addr reset to 0. A transfer handshaked in that same cycle still completes. Memory keeps whatever was already written.
- Memory contents are not reset by rst_n; they are undefined until written or cleared.
- Arithmetic: addr and col are unsigned, compared against DEPTH-1 and IMG_W-1 only. No other wrap is possible.

## Timing
- Reset values: state = IDLE, addr = 0, col = 0, wr_ready = 0, rd_valid = 0, rd_data = 0, rd_eol = 0, rd_last = 0, busy = 0, done = 0.
- Command sampled at edge N while in IDLE → state entered at N+1. First wr_ready/rd_valid is visible in the cycle after N+1's edge, i.e. one cycle after acceptance.
- done is registered: high for exactly the one cycle in which the state is IDLE after the final transfer. A new command may be accepted in that same cycle.
- Full-frame cost with no stalls: DEPTH+1 cycles for WRITE/READ/CLEAR, including the acceptance cycle.
- wr_ready and rd_valid are functions of state only; there is no combinational path from wr_valid or rd_ready to any output.
- DEPTH = 1: a single transfer completes the command and done pulses on the next cycle.

## Configuration
- PFB_CLEAR_EN:
  - Defined: CLEAR state and the clear input behave as above.
  - Undefined: the clear input is ignored (commands decode on rw only), the CLEAR state and CLR_VAL logic are not built, and behaviour is otherwise identical.

## Test plan
All scenarios use DW = 8, IMG_W = 4, IMG_H = 2, CLR_VAL = 0, macro defined.
- Reset mid-WRITE after 3 pixels → all outputs at reset values immediately. A following READ returns the 3 written pixels at addr 0–2.
- Write 8'h10…8'h17 with wr_valid low every other cycle, then READ with rd_ready = 1:
  - rd_data 10…17 in order; rd_eol on 13 and 17; rd_last on 17.
  - Each command pulses done once.
- READ with rd_ready toggling 1,0,0,1…: rd_data/rd_eol/rd_last held during stalls; exactly 8 transfers; done one cycle after the 17 transfer.
- clear = 1 and rw = 1 both asserted at acceptance:
  - CLEAR wins, busy for 8 cycles, done pulses.
  - A subsequent READ returns eight 8'h00.
- enable dropped in cycle 4 of WRITE: no done pulse, busy = 0 next cycle. A subsequent READ shows the new data at addr 0–3 and the old data at 4–7.
- Back-to-back: READ accepted in the done cycle of a WRITE → rd_valid one cycle later, rd_data = first written pixel.

Source files
------------

// File: rtl/pixel_frame_buffer.sv
// pixel_frame_buffer: single-port IMG_W x IMG_H frame store with valid/ready pixel streams
// and row/frame markers on the read side. Define PFB_CLEAR_EN to build the clear command.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for enable; addr/col parked at 0; done may pulse here
// S_WRITE | accepting upstream pixels into mem[addr]
// S_READ  | presenting mem[addr] downstream
// S_CLEAR | writing CLR_VAL to one location per cycle (PFB_CLEAR_EN only)
module pixel_frame_buffer #(
    parameter int              DW      = 8,
    parameter int              IMG_W   = 2,
    parameter int              IMG_H   = 2,
    parameter logic [DW-1:0]   CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          rw,
    input  logic          clear,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_eol,
    output logic          rd_last,
    output logic          busy,
    output logic          done
);

    localparam int DEPTH = IMG_W * IMG_H;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
`ifdef PFB_CLEAR_EN
        ,
        S_CLEAR = 2'd3
`endif
    } state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic [CW-1:0] col;

    logic [DW-1:0] mem [DEPTH];

    logic          xfer;
    logic          at_last;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] addr_inc;
    logic [CW-1:0] col_next;

    assign at_last  = (addr == LAST_ADDR);
    assign addr_inc = addr + AW'(1);
    assign col_next = (col == LAST_COL) ? '0 : col + CW'(1);

    // xfer marks a cycle in which the current location is consumed and addr may advance
    always_comb begin
        xfer      = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = wr_data;
        case (state)
            S_WRITE: begin
                xfer   = wr_valid;
                mem_we = wr_valid;
            end
            S_READ: begin
                xfer = rd_ready;
            end
`ifdef PFB_CLEAR_EN
            S_CLEAR: begin
                xfer      = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = CLR_VAL;
            end
`endif
            default: begin
                xfer = 1'b0;
            end
        endcase
    end

`ifndef PFB_CLEAR_EN
    logic unused_clear;
    assign unused_clear = clear;
`endif

    // Frame contents deliberately survive rst_n
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            addr  <= '0;
            col   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                addr <= '0;
                col  <= '0;
                if (enable) begin
`ifdef PFB_CLEAR_EN
                    if (clear) begin
                        state <= S_CLEAR;
                    end else
`endif
                    if (rw) begin
                        state <= S_WRITE;
                    end else begin
                        state <= S_READ;
                    end
                end
            end else if (!enable) begin
                // abort: any same-cycle handshake has already been honoured by the memory port
                state <= S_IDLE;
                addr  <= '0;
                col   <= '0;
            end else if (xfer) begin
                if (at_last) begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                    addr  <= '0;
                    col   <= '0;
                end else begin
                    addr <= addr_inc;
                    col  <= col_next;
                end
            end
        end
    end

    assign busy     = (state != S_IDLE);
    assign wr_ready = (state == S_WRITE);
    assign rd_valid = (state == S_READ);
    assign rd_data  = rd_valid ? mem[addr] : '0;
    assign rd_eol   = rd_valid & (col == LAST_COL);
    assign rd_last  = rd_valid & at_last;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Directed bench for pixel_frame_buffer (4x2 frame, 8-bit pixels) with a read-beat scoreboard.
module tb_pixel_frame_buffer;

    localparam int DW    = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int DEPTH = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          rw;
    logic          clear;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_eol;
    logic          rd_last;
    logic          busy;
    logic          done;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          eol;
        logic          last;
    } beat_t;

    beat_t         sb [$];
    logic [DW-1:0] model [DEPTH];
    int            checks = 0;
    int            errors = 0;

    pixel_frame_buffer #(
        .DW     (DW),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .CLR_VAL(8'h00)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .rw      (rw),
        .clear   (clear),
        .wr_valid(wr_valid),
        .wr_data (wr_data),
        .wr_ready(wr_ready),
        .rd_ready(rd_ready),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .rd_eol  (rd_eol),
        .rd_last (rd_last),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy",     32'(busy),     0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data",  32'(rd_data),  0);
        chk("rst_rd_eol",   32'(rd_eol),   0);
        chk("rst_rd_last",  32'(rd_last),  0);
        chk("rst_done",     32'(done),     0);
    endtask

    task automatic go_idle();
        enable = 1'b0;
        rw     = 1'b0;
        clear  = 1'b0;
        @(negedge clk);
        chk("idle_done_low", 32'(done), 0);
        chk("idle_busy_low", 32'(busy), 0);
    endtask

    // Called at a negedge; returns at the negedge of the first IDLE cycle with enable still high
    // unless aborted, so the caller may launch the next command in the done cycle.
    task automatic run_write(input logic [DW-1:0] base, input bit gaps, input int abort_at);
        int idx = 0;
        int cyc = 0;
        bit aborted = 1'b0;
        enable   = 1'b1;
        rw       = 1'b1;
        clear    = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        while (idx < DEPTH && !aborted && cyc < 64) begin
            cyc++;
            chk("wr_ready",    32'(wr_ready), 1);
            chk("wr_busy",     32'(busy),     1);
            chk("wr_done_low", 32'(done),     0);
            wr_valid = gaps ? (cyc % 2 == 1) : 1'b1;
            if (wr_valid) begin
                wr_data    = 8'(base + 8'(idx));
                model[idx] = wr_data;
                idx++;
            end
            if (cyc == abort_at) begin
                enable  = 1'b0;
                aborted = 1'b1;
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("wr_end_busy",  32'(busy),     0);
        chk("wr_end_ready", 32'(wr_ready), 0);
        chk("wr_end_done",  32'(done),     32'(!aborted));
    endtask

    // Reads n beats; aborts with the final handshake when n < DEPTH.
    task automatic run_read(input int n, input bit stall);
        beat_t b;
        int got = 0;
        int cyc = 0;
        for (int i = 0; i < n; i++) begin
            b.d    = model[i];
            b.eol  = ((i % IMG_W) == IMG_W - 1);
            b.last = (i == DEPTH - 1);
            sb.push_back(b);
        end
        enable   = 1'b1;
        rw       = 1'b0;
        clear    = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
        while (got < n && cyc < 64) begin
            chk("rd_valid",    32'(rd_valid), 1);
            chk("rd_done_low", 32'(done),     0);
            if (sb.size() > 0) begin
                chk("rd_data", 32'(rd_data), 32'(sb[0].d));
                chk("rd_eol",  32'(rd_eol),  32'(sb[0].eol));
                chk("rd_last", 32'(rd_last), 32'(sb[0].last));
            end
            rd_ready = stall ? (cyc % 3 == 0) : 1'b1;
            if (rd_ready) begin
                void'(sb.pop_front());
                got++;
                if (got == n && n < DEPTH) enable = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        chk("rd_count",        32'(got),       32'(n));
        chk("rd_sb_empty",     32'(sb.size()), 0);
        chk("rd_end_busy",     32'(busy),      0);
        chk("rd_end_valid",    32'(rd_valid),  0);
        chk("rd_end_data",     32'(rd_data),   0);
        chk("rd_end_done",     32'(done),      32'(n == DEPTH));
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        rw       = 1'b0;
        clear    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // reset in the middle of a write; the three committed pixels must survive
        enable = 1'b1;
        rw     = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("mid_wr_ready", 32'(wr_ready), 1);
            wr_valid = 1'b1;
            wr_data  = 8'(8'hA0 + 8'(i));
            model[i] = wr_data;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        enable   = 1'b0;
        rw       = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_read(3, 1'b0);
        go_idle();

        // gapped write, straight read, then stalled read
        run_write(8'h10, 1'b1, 0);
        go_idle();
        run_read(DEPTH, 1'b0);
        go_idle();
        run_read(DEPTH, 1'b1);
        go_idle();

        // abort in cycle 4 of a write: addr 0-3 new, 4-7 old
        run_write(8'h20, 1'b0, 4);
        go_idle();
        run_read(DEPTH, 1'b0);
        go_idle();

`ifdef PFB_CLEAR_EN
        begin
            int cyc = 0;
            enable = 1'b1;
            clear  = 1'b1;
            rw     = 1'b1;
            @(negedge clk);
            while (busy && cyc < 64) begin
                cyc++;
                chk("clr_wr_ready", 32'(wr_ready), 0);
                chk("clr_done_low", 32'(done),     0);
                @(negedge clk);
            end
            chk("clr_busy_cycles", 32'(cyc),  32'(DEPTH));
            chk("clr_done",        32'(done), 1);
            for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
            go_idle();
            run_read(DEPTH, 1'b0);
            go_idle();
        end
`else
        enable = 1'b1;
        clear  = 1'b1;
        rw     = 1'b1;
        @(negedge clk);
        chk("clr_ignored_wr_ready", 32'(wr_ready), 1);
        go_idle();
`endif

        // back-to-back: read launched in the write's done cycle
        run_write(8'h30, 1'b0, 0);
        run_read(DEPTH, 1'b0);
        go_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
